// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: wide-op FSM encoding, RAM sizing and stack direction.
package mem_stage_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 11;
   localparam int unsigned DATA_W         = 16;
   localparam int unsigned SP_W           = 32;

   // Stack grows toward lower addresses: push decrements, pop increments.
   localparam logic [SP_W-1:0] SP_STEP  = SP_W'(1);
   localparam logic [SP_W-1:0] SP_STEP2 = SP_W'(2);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SECOND = 1'b1
   } wide_state_e;

endpackage

// File: rtl/memory_stage_data_memory.sv
// Single-port data RAM: synchronous write, asynchronous read, contents survive reset.
module data_memory
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: loads/stores, narrow stack ops and two-cycle wide (PC) push/pop.
module memory_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              push_in,
   input  logic              pop_in,
   input  logic              wide_in,
   input  logic              wb_en_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic [DATA_W-1:0] address_in,
   input  logic [3:0]        reg_dst_num_in,
   input  logic [SP_W-1:0]   sp_in,
   input  logic [SP_W-1:0]   pc_in,
   output logic              stall_out,
   output logic [DATA_W-1:0] wb_value_out,
   output logic [3:0]        reg_dst_num_out,
   output logic              wb_en_out,
   output logic [SP_W-1:0]   sp_out,
   output logic              pc_load_out,
   output logic [SP_W-1:0]   pc_value_out
);

   wide_state_e       state, state_next;
   logic [DATA_W-1:0] low_half;
   logic              latch_low;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   data_memory #(.ADDR_W(ADDR_W)) u_data_memory (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         low_half <= '0;
      end else begin
         state <= state_next;
         if (latch_low) low_half <= ram_rdata;
      end
   end

   // Operation decode; push > pop > store > load, and the EM register holds inputs across SECOND.
   always_comb begin
      state_next   = ST_IDLE;
      ram_we       = 1'b0;
      ram_addr     = ADDR_W'(result_in);
      ram_wdata    = address_in;
      wb_value_out = result_in;
      wb_en_out    = wb_en_in;
      sp_out       = sp_in;
      stall_out    = 1'b0;
      pc_load_out  = 1'b0;
      latch_low    = 1'b0;

      if (push_in) begin
         wb_en_out = 1'b0;
         ram_we    = 1'b1;
         if (wide_in && state == ST_IDLE) begin
            ram_addr   = ADDR_W'(sp_in);
            ram_wdata  = pc_in[31:16];
            stall_out  = 1'b1;
            state_next = ST_SECOND;
         end else if (wide_in) begin
            ram_addr  = ADDR_W'(sp_in - SP_STEP);
            ram_wdata = pc_in[15:0];
            sp_out    = sp_in - SP_STEP2;
         end else begin
            ram_addr = ADDR_W'(sp_in);
            sp_out   = sp_in - SP_STEP;
         end
      end else if (pop_in) begin
         if (wide_in && state == ST_IDLE) begin
            ram_addr   = ADDR_W'(sp_in + SP_STEP);
            latch_low  = 1'b1;
            stall_out  = 1'b1;
            wb_en_out  = 1'b0;
            state_next = ST_SECOND;
         end else if (wide_in) begin
            ram_addr    = ADDR_W'(sp_in + SP_STEP2);
            pc_load_out = 1'b1;
            sp_out      = sp_in + SP_STEP2;
         end else begin
            ram_addr     = ADDR_W'(sp_in + SP_STEP);
            wb_value_out = ram_rdata;
            sp_out       = sp_in + SP_STEP;
         end
      end else if (mem_write_in) begin
         ram_we    = 1'b1;
         wb_en_out = 1'b0;
      end else if (mem_read_in) begin
         wb_value_out = ram_rdata;
      end

      // Reset cycle: abort any wide op and suppress all side effects.
      if (!reset) begin
         state_next  = ST_IDLE;
         ram_we      = 1'b0;
         latch_low   = 1'b0;
         stall_out   = 1'b0;
         pc_load_out = 1'b0;
         wb_en_out   = 1'b0;
      end
   end

   assign pc_value_out    = {ram_rdata, low_half};
   assign reg_dst_num_out = reg_dst_num_in;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a word-array RAM and stack-rule reference model.
module tb_memory_stage;

   localparam int unsigned AW    = 11;
   localparam int unsigned DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        reset, mem_read, mem_write, push, pop, wide, wb_en;
   logic [15:0] result, address;
   logic [3:0]  reg_dst;
   logic [31:0] sp, pc;
   logic        stall_out, wb_en_out, pc_load_out;
   logic [15:0] wb_value_out;
   logic [3:0]  reg_dst_out;
   logic [31:0] sp_out, pc_value_out;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [15:0] ref_mem [DEPTH];

   always #5 clk = ~clk;

   memory_stage #(.ADDR_W(AW)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_read_in     (mem_read),
      .mem_write_in    (mem_write),
      .push_in         (push),
      .pop_in          (pop),
      .wide_in         (wide),
      .wb_en_in        (wb_en),
      .result_in       (result),
      .address_in      (address),
      .reg_dst_num_in  (reg_dst),
      .sp_in           (sp),
      .pc_in           (pc),
      .stall_out       (stall_out),
      .wb_value_out    (wb_value_out),
      .reg_dst_num_out (reg_dst_out),
      .wb_en_out       (wb_en_out),
      .sp_out          (sp_out),
      .pc_load_out     (pc_load_out),
      .pc_value_out    (pc_value_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned ix(input logic [31:0] a);
      return int'(a) & (DEPTH - 1);
   endfunction

   task automatic idle_inputs();
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; push = 1'b0; pop = 1'b0;
      wide = 1'b0; wb_en = 1'b0; result = '0; address = '0; reg_dst = '0; sp = '0; pc = '0;
   endtask

   // One single-cycle operation; the model applies the priority rules directly.
   task automatic narrow(input logic rd, input logic wr, input logic ph, input logic pp,
                         input logic wd, input logic we, input logic [15:0] res,
                         input logic [15:0] adr, input logic [31:0] s);
      logic [31:0] exp_sp;
      logic        exp_we;
      logic        val_defined;
      logic [15:0] exp_val;
      @(negedge clk);
      reset = 1'b1; mem_read = rd; mem_write = wr; push = ph; pop = pp; wide = wd;
      wb_en = we; result = res; address = adr; sp = s; pc = $urandom;
      reg_dst = 4'($urandom);
      #1;
      exp_sp = s; exp_we = we; exp_val = res; val_defined = 1'b1;
      if (ph) begin
         exp_sp = s - 1; exp_we = 1'b0; val_defined = 1'b0;
      end else if (pp) begin
         exp_val = ref_mem[ix(s + 1)]; exp_sp = s + 1;
      end else if (wr) begin
         exp_we = 1'b0; val_defined = 1'b0;
      end else if (rd) begin
         exp_val = ref_mem[ix(32'(res))];
      end
      if (val_defined) check("wb_value", 32'(wb_value_out), 32'(exp_val));
      check("wb_en", 32'(wb_en_out), 32'(exp_we));
      check("sp_out", sp_out, exp_sp);
      check("stall", 32'(stall_out), 32'd0);
      check("pc_load", 32'(pc_load_out), 32'd0);
      check("reg_dst", 32'(reg_dst_out), 32'(reg_dst));
      if (ph) ref_mem[ix(s)] = adr;
      else if (!pp && wr) ref_mem[ix(32'(res))] = adr;
   endtask

   // Two-cycle PC push or pop; abort=1 asserts reset during the second cycle.
   task automatic wide_op(input logic is_pop, input logic [31:0] pcv, input logic [31:0] s,
                          input logic we, input logic abort);
      @(negedge clk);
      idle_inputs();
      push = !is_pop; pop = is_pop; wide = 1'b1; wb_en = we; sp = s; pc = pcv;
      result = 16'($urandom); address = 16'($urandom);
      #1;
      check("w1_stall", 32'(stall_out), 32'd1);
      check("w1_sp", sp_out, s);
      check("w1_wb_en", 32'(wb_en_out), 32'd0);
      check("w1_pc_load", 32'(pc_load_out), 32'd0);
      if (!is_pop) ref_mem[ix(s)] = pcv[31:16];
      @(negedge clk);
      if (abort) reset = 1'b0;
      #1;
      check("w2_stall", 32'(stall_out), 32'd0);
      if (abort) begin
         check("abort_pc_load", 32'(pc_load_out), 32'd0);
         check("abort_wb_en", 32'(wb_en_out), 32'd0);
      end else if (is_pop) begin
         check("w2_pc_load", 32'(pc_load_out), 32'd1);
         check("w2_pc_value", pc_value_out, {ref_mem[ix(s + 2)], ref_mem[ix(s + 1)]});
         check("w2_sp", sp_out, s + 2);
         check("w2_wb_en", 32'(wb_en_out), 32'(we));
      end else begin
         check("w2_sp", sp_out, s - 2);
         check("w2_wb_en", 32'(wb_en_out), 32'd0);
         check("w2_pc_load", 32'(pc_load_out), 32'd0);
         ref_mem[ix(s - 1)] = pcv[15:0];
      end
      @(negedge clk);
      idle_inputs();
      #1;
      check("w3_stall", 32'(stall_out), 32'd0);
      check("w3_pc_load", 32'(pc_load_out), 32'd0);
   endtask

   function automatic logic [31:0] rand_sp();
      case ($urandom_range(0, 4))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 4095));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic rd, wr, ph, pp, wd;
      idle_inputs();

      // Reset cycle with a wide push pending: no stall, no pulse, no write-back.
      @(negedge clk);
      reset = 1'b0; push = 1'b1; wide = 1'b1; wb_en = 1'b1; sp = 32'h7FF;
      #1;
      check("rst_stall", 32'(stall_out), 32'd0);
      check("rst_pc_load", 32'(pc_load_out), 32'd0);
      check("rst_wb_en", 32'(wb_en_out), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("post_rst_stall", 32'(stall_out), 32'd0);

      // Give every RAM word a known value.
      for (int i = 0; i < int'(DEPTH); i++)
         narrow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'(i), 16'($urandom), 32'h0);

      // A store during reset must not land.
      @(negedge clk);
      idle_inputs();
      reset = 1'b0; mem_write = 1'b1; result = 16'h0020; address = ~ref_mem[16'h0020];
      narrow(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0, 32'h0);

      narrow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 32'h0);
      narrow(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0, 32'h0);
      check("store_load_const", 32'(wb_value_out), 32'h0000_BEEF);

      narrow(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h1234, 32'h7FF);
      narrow(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 32'h7FE);
      check("push_pop_const", 32'(wb_value_out), 32'h0000_1234);

      wide_op(1'b0, 32'h00AB_CDEF, 32'h7FF, 1'b1, 1'b0);
      narrow(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h07FF, 16'h0, 32'h0);
      check("wpush_hi_const", 32'(wb_value_out), 32'h0000_00AB);
      narrow(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h07FE, 16'h0, 32'h0);
      check("wpush_lo_const", 32'(wb_value_out), 32'h0000_CDEF);
      wide_op(1'b1, 32'h0, 32'h7FD, 1'b0, 1'b0);

      // SP wrap both ways; index 0 is where the push lands.
      narrow(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h5A5A, 32'h0);
      narrow(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0, 32'h0);
      narrow(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 32'hFFFF_FFFF);

      // Reset in SECOND of a wide push leaves RAM[sp-1] alone, then a fresh wide op works.
      wide_op(1'b0, 32'h1357_9BDF, 32'h400, 1'b0, 1'b1);
      narrow(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h03FF, 16'h0, 32'h0);
      wide_op(1'b1, 32'h0, 32'h100, 1'b1, 1'b1);
      wide_op(1'b0, 32'hCAFE_F00D, 32'h400, 1'b0, 1'b0);

      // wide without push/pop behaves as a plain load.
      narrow(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0, 32'h0);

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            7:       wide_op(1'b0, $urandom, rand_sp(), 1'($urandom), 1'b0);
            8:       wide_op(1'b1, $urandom, rand_sp(), 1'($urandom), 1'b0);
            9:       wide_op(1'($urandom), $urandom, rand_sp(), 1'($urandom), 1'b1);
            default: begin
               rd = 1'($urandom); wr = 1'($urandom);
               ph = ($urandom_range(0, 3) == 0); pp = ($urandom_range(0, 2) == 0);
               wd = (ph || pp) ? 1'b0 : 1'($urandom);
               narrow(rd, wr, ph, pp, wd, 1'($urandom), 16'($urandom), 16'($urandom), rand_sp());
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
